alarm_controller: RTL and testbench
===================================

# alarm_controller

Main alarm state machine, directly downstream of the keypad code checker. Consumes the checker's 2-bit `KEY_STATUS` verdict and the zone sensor inputs. Runs the arm/disarm sequence with exit delay, entry delay and timed siren. Drives the siren, the armed LED, the beeper and a debug state bus.

## Interface
- `TICK_CYCLES`, default 12_000_000: `CLK` cycles per 1 s tick. Reduced in simulation.
- `N_SENSORS`, default 4: number of zone inputs.
- `EXIT_DELAY_S`, default 10: exit delay in ticks.
- `ENTRY_DELAY_S`, default 10: entry delay in ticks.
- `SIREN_S`, default 60: siren duration in ticks.
- `MAX_ERRORS`, default 3: wrong codes that trigger lockout (LOCKOUT_EN only).
- `LOCKOUT_S`, default 30: lockout duration in ticks (LOCKOUT_EN only).

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `KEY_STATUS` in 2: code verdict from the checker.
  - 0 = KEY_OK, 2 = KEY_ERROR, 3 = NO_KEY.
  - 1 is illegal and treated as NO_KEY.
- `SENSOR` in N_SENSORS: zone inputs, active-high, asynchronous.
- `SIREN` out 1: siren drive.
- `ARMED_LED` out 1: armed indicator.
- `BEEP` out 1: delay beeper.
- `LOCKED` out 1: keypad lockout active; constant 0 without LOCKOUT_EN.
- `DEBUG_STATE` out 3: current state encoding.

## Operation
- `KEY_STATUS` is registered once into `ks_q`, then `ks_q2`.
- A code event fires for one cycle when `ks_q` is OK/ERROR and `ks_q2` was NO_KEY. A multi-cycle verdict therefore counts once.
- `SENSOR` passes through a 2-flop synchronizer. `trip` = OR of the synchronized bits.
- Single down-counter `tmr`, width $clog2 of the largest delay parameter plus 1.
  - Loaded on entry to each timed state.
  - Decremented on `tick`.
  - Expiry = `tick` while `tmr`==1.
- States (`DEBUG_STATE` value):
  - DISARMED (0): ok → EXIT_DELAY, load EXIT_DELAY_S. Sensors ignored.
  - EXIT_DELAY (1): ok → DISARMED. Expiry → ARMED. Sensors ignored.
  - ARMED (2): ok → DISARMED. `trip` → ENTRY_DELAY, load ENTRY_DELAY_S.
  - ENTRY_DELAY (3): ok → DISARMED. Expiry → ALARM, load SIREN_S.
  - ALARM (4): ok → DISARMED. Expiry → ARMED; re-arm, siren off.
  - Codes 5–7 are unreachable and recover to DISARMED on the next clock.
- Priority within a cycle: accepted ok > expiry > `trip`.
- Output decode:
  - `SIREN` = ALARM.
  - `ARMED_LED` = ARMED, ENTRY_DELAY or ALARM.
  - `BEEP` toggles on each tick during EXIT_DELAY and ENTRY_DELAY; 0 elsewhere.
- KEY_ERROR has no effect on the main state machine.

## Timing
- All outputs come from registers or are decodes of registered state. No combinational input-to-output paths.
- Reset values:
  - State DISARMED, `tmr`=0.
  - `SIREN`, `ARMED_LED`, `BEEP`, `LOCKED` = 0; `DEBUG_STATE`=0.
  - Error counter 0; prescaler 0.
- `KEY_STATUS` leaves NO_KEY before edge k → state updates at edge k+1.
- `SENSOR` rises before edge k → ENTRY_DELAY visible after edge k+2.
- Prescaler: `tick` is a 1-cycle pulse every TICK_CYCLES cycles, free-running from reset.
  - A delay of N ticks lasts between (N-1)·TICK_CYCLES+1 and N·TICK_CYCLES cycles.
- Reset asserted mid-operation clears everything immediately, including the siren.
  - Release is synchronous to the next `CLK` edge.

## Configuration
- `ALARM_LOCKOUT_EN` defined:
  - A saturating error counter counts KEY_ERROR events.
  - The counter clears on an accepted ok and at lockout end.
  - When the counter reaches MAX_ERRORS, `LOCKED`=1 for LOCKOUT_S ticks, using a dedicated lockout timer independent of `tmr`.
  - While locked, all code events are discarded.
  - The main state machine keeps running, so an entry delay still expires into ALARM.
- Not defined:
  - No error counter and no lockout timer.
  - `LOCKED` tied to 0.
  - Every KEY_OK is accepted.

## Structure
- Package `alarm_pkg` holds:
  - KEY_OK / KEY_ERROR / NO_KEY constants, shared with the code checker.
  - The state encoding constants.
- Sub-module `tick_gen` (parameter TICK_CYCLES; ports CLK, RST_N, TICK) holds the 1 s prescaler.

## Test plan
Common bench settings: TICK_CYCLES=10, EXIT_DELAY_S=3, ENTRY_DELAY_S=2, SIREN_S=4, MAX_ERRORS=3, LOCKOUT_S=5.

- **Arm:** `KEY_STATUS`=0 for 1 cycle from DISARMED → DEBUG_STATE=1 after 2 edges, `BEEP` toggling, DEBUG_STATE=2 within 30 cycles, `ARMED_LED`=1.
- **Intrusion:** from ARMED, `SENSOR`=4'b0100 → DEBUG_STATE=3 after 3 edges, then DEBUG_STATE=4 within 20 cycles with `SIREN`=1; `SIREN`=0 and DEBUG_STATE=2 within 40 more cycles.
- **Disarm vs expiry:** in ENTRY_DELAY, place KEY_OK so it lands on the expiry cycle → DEBUG_STATE=0, `SIREN` never 1.
- **Held verdict:** `KEY_STATUS`=0 held 5 cycles in DISARMED → exactly one transition, remains in EXIT_DELAY.
- **Lockout (ALARM_LOCKOUT_EN):** three KEY_ERROR pulses → `LOCKED`=1; KEY_OK during lock ignored; `LOCKED`=0 after ≤50 cycles, then KEY_OK accepted.
- **Reset mid-alarm:** `RST_N`=0 during ALARM → `SIREN`=0 and DEBUG_STATE=0 with no clock edge required.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: keypad verdict codes and alarm state encoding shared by the alarm datapath
package alarm_pkg;
  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;
  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;
  function automatic logic no_key(input logic [1:0] ks);
    return ks == NO_KEY || ks == 2'd1;
  endfunction
endpackage

// File: rtl/alarm_controller_tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle TICK every TICK_CYCLES clocks
module tick_gen #(
  parameter int TICK_CYCLES = 12_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);
  localparam int CW = $clog2(TICK_CYCLES + 1);
  logic [CW-1:0] cnt;
  // wrap the counter and pulse TICK on the wrap cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else begin
      TICK <= cnt == CW'(TICK_CYCLES - 1);
      cnt  <= (cnt == CW'(TICK_CYCLES - 1)) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: arm/disarm FSM with exit/entry delays and timed siren; ALARM_LOCKOUT_EN adds keypad lockout
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int TICK_CYCLES   = 12_000_000,
  parameter int N_SENSORS     = 4,
  parameter int EXIT_DELAY_S  = 10,
  parameter int ENTRY_DELAY_S = 10,
  parameter int SIREN_S       = 60,
  parameter int MAX_ERRORS    = 3,
  parameter int LOCKOUT_S     = 30
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [1:0]           KEY_STATUS,
  input  logic [N_SENSORS-1:0] SENSOR,
  output logic                 SIREN,
  output logic                 ARMED_LED,
  output logic                 BEEP,
  output logic                 LOCKED,
  output logic [2:0]           DEBUG_STATE
);
  localparam int MAXD_A = EXIT_DELAY_S > ENTRY_DELAY_S ? EXIT_DELAY_S : ENTRY_DELAY_S;
  localparam int MAXD   = MAXD_A > SIREN_S ? MAXD_A : SIREN_S;
  localparam int TW     = $clog2(MAXD) + 1;
  logic [1:0] ks_q, ks_q2;
  logic [N_SENSORS-1:0] s_meta, s_sync;
  logic [TW-1:0] tmr, ld_val;
  logic tick, ok_ev, err_ev, ok, trip, expire, ld;
  state_t state_q, state_d;
  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .TICK (tick)
  );
  // verdict edge detection and sensor synchronization
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ks_q   <= NO_KEY;
      ks_q2  <= NO_KEY;
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      ks_q   <= KEY_STATUS;
      ks_q2  <= ks_q;
      s_meta <= SENSOR;
      s_sync <= s_meta;
    end
  end
  assign ok_ev  = ks_q == KEY_OK && no_key(ks_q2);
  assign err_ev = ks_q == KEY_ERROR && no_key(ks_q2);
  assign trip   = |s_sync;
  assign expire = tick && tmr == TW'(1);
`ifdef ALARM_LOCKOUT_EN
  localparam int EW = $clog2(MAX_ERRORS + 1);
  localparam int LW = $clog2(LOCKOUT_S) + 1;
  logic [EW-1:0] err_cnt;
  logic [LW-1:0] lock_tmr;
  assign ok = ok_ev && !LOCKED;
  // count wrong codes and hold the keypad locked for LOCKOUT_S ticks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt  <= '0;
      lock_tmr <= '0;
      LOCKED   <= 1'b0;
    end else if (LOCKED) begin
      if (tick) lock_tmr <= lock_tmr - LW'(1);
      if (tick && lock_tmr == LW'(1)) begin
        LOCKED  <= 1'b0;
        err_cnt <= '0;
      end
    end else if (ok_ev) begin
      err_cnt <= '0;
    end else if (err_ev) begin
      err_cnt  <= err_cnt + EW'(err_cnt != EW'(MAX_ERRORS));
      LOCKED   <= err_cnt == EW'(MAX_ERRORS - 1);
      lock_tmr <= LW'(LOCKOUT_S);
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{err_ev, MAX_ERRORS[0], LOCKOUT_S[0]};
  assign ok     = ok_ev;
  assign LOCKED = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_DISARMED;
    else state_q <= state_d;
  end
  // next state: accepted ok beats expiry beats trip; timed states load tmr on entry
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = '0;
    case (state_q)
      ST_DISARMED: if (ok) begin
        state_d = ST_EXIT;
        ld      = 1'b1;
        ld_val  = TW'(EXIT_DELAY_S);
      end
      ST_EXIT: state_d = ok ? ST_DISARMED : expire ? ST_ARMED : ST_EXIT;
      ST_ARMED: if (ok) state_d = ST_DISARMED;
        else if (trip) begin
          state_d = ST_ENTRY;
          ld      = 1'b1;
          ld_val  = TW'(ENTRY_DELAY_S);
        end
      ST_ENTRY: if (ok) state_d = ST_DISARMED;
        else if (expire) begin
          state_d = ST_ALARM;
          ld      = 1'b1;
          ld_val  = TW'(SIREN_S);
        end
      ST_ALARM: state_d = ok ? ST_DISARMED : expire ? ST_ARMED : ST_ALARM;
      default: state_d = ST_DISARMED;
    endcase
  end
  // shared delay timer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tmr <= '0;
    else if (ld) tmr <= ld_val;
    else if (tick && tmr != '0) tmr <= tmr - TW'(1);
  end
  // beeper toggles per tick while staying in a delay state, cleared on any transition
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) BEEP <= 1'b0;
    else BEEP <= (state_d == ST_EXIT || state_d == ST_ENTRY) && state_d == state_q ? BEEP ^ tick : 1'b0;
  end
  // output decode of registered state
  always_comb begin
    SIREN       = state_q == ST_ALARM;
    ARMED_LED   = state_q == ST_ARMED || state_q == ST_ENTRY || state_q == ST_ALARM;
    DEBUG_STATE = state_q;
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed self-checking bench for alarm_controller (lockout steps under ALARM_LOCKOUT_EN)
module tb_alarm_controller;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic [1:0] KEY_STATUS = 2'd3;
  logic [3:0] SENSOR = 4'b0;
  logic SIREN, ARMED_LED, BEEP, LOCKED;
  logic [2:0] DEBUG_STATE;
  int n_cmp = 0;
  int n_err = 0;
  logic siren_seen = 1'b0;
`ifdef ALARM_LOCKOUT_EN
  localparam logic LOCK_EXP = 1'b1;
`else
  localparam logic LOCK_EXP = 1'b0;
`endif
  alarm_controller #(
    .TICK_CYCLES(10), .N_SENSORS(4), .EXIT_DELAY_S(3), .ENTRY_DELAY_S(2),
    .SIREN_S(4), .MAX_ERRORS(3), .LOCKOUT_S(5)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .KEY_STATUS(KEY_STATUS), .SENSOR(SENSOR),
    .SIREN(SIREN), .ARMED_LED(ARMED_LED), .BEEP(BEEP), .LOCKED(LOCKED),
    .DEBUG_STATE(DEBUG_STATE)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (SIREN) siren_seen = 1'b1;
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [2:0] probe(input int sel);
    return sel == 0 ? DEBUG_STATE : sel == 1 ? {2'b0, BEEP} : sel == 2 ? {2'b0, LOCKED} : {2'b0, SIREN};
  endfunction
  task automatic wait_for(input string tag, input int sel, input logic [2:0] val, input int budget);
    int n = 0;
    while (probe(sel) !== val && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {1'b0, probe(sel)}, {1'b0, val});
  endtask
  task automatic key_pulse(input logic [1:0] k);
    KEY_STATUS = k;
    step(1);
    KEY_STATUS = 2'd3;
    step(1);
  endtask
  initial begin
    #2 RST_N = 1'b0;
    #1;
    chk("rst_state", {1'b0, DEBUG_STATE}, 4'd0);
    chk("rst_siren", {3'b0, SIREN}, 4'd0);
    chk("rst_led", {3'b0, ARMED_LED}, 4'd0);
    chk("rst_beep", {3'b0, BEEP}, 4'd0);
    chk("rst_locked", {3'b0, LOCKED}, 4'd0);
    step(3);
    RST_N = 1'b1;
    step(2);
    chk("idle_state", {1'b0, DEBUG_STATE}, 4'd0);
    KEY_STATUS = 2'd0;
    step(1);
    KEY_STATUS = 2'd3;
    chk("arm_edge1", {1'b0, DEBUG_STATE}, 4'd0);
    step(1);
    chk("arm_edge2", {1'b0, DEBUG_STATE}, 4'd1);
    chk("arm_led_exit", {3'b0, ARMED_LED}, 4'd0);
    wait_for("arm_beep_on", 1, 3'd1, 12);
    wait_for("arm_beep_off", 1, 3'd0, 12);
    wait_for("arm_armed", 0, 3'd2, 30);
    chk("arm_led", {3'b0, ARMED_LED}, 4'd1);
    chk("arm_beep_quiet", {3'b0, BEEP}, 4'd0);
    SENSOR = 4'b0100;
    step(2);
    chk("intr_edge2", {1'b0, DEBUG_STATE}, 4'd2);
    step(1);
    chk("intr_edge3", {1'b0, DEBUG_STATE}, 4'd3);
    SENSOR = 4'b0;
    wait_for("intr_alarm", 0, 3'd4, 20);
    chk("intr_siren_on", {3'b0, SIREN}, 4'd1);
    chk("intr_led", {3'b0, ARMED_LED}, 4'd1);
    wait_for("intr_rearm", 0, 3'd2, 40);
    chk("intr_siren_off", {3'b0, SIREN}, 4'd0);
    SENSOR = 4'b0001;
    wait_for("race_entry", 0, 3'd3, 5);
    SENSOR = 4'b0;
    siren_seen = 1'b0;
    wait_for("race_first_tick", 1, 3'd1, 12);
    step(8);
    KEY_STATUS = 2'd0;
    step(1);
    KEY_STATUS = 2'd3;
    chk("race_pre_expiry", {1'b0, DEBUG_STATE}, 4'd3);
    step(1);
    chk("race_disarmed", {1'b0, DEBUG_STATE}, 4'd0);
    step(3);
    chk("race_no_siren", {3'b0, siren_seen}, 4'd0);
    KEY_STATUS = 2'd0;
    step(1);
    chk("hold_edge1", {1'b0, DEBUG_STATE}, 4'd0);
    step(1);
    chk("hold_edge2", {1'b0, DEBUG_STATE}, 4'd1);
    step(3);
    KEY_STATUS = 2'd3;
    step(2);
    chk("hold_once", {1'b0, DEBUG_STATE}, 4'd1);
    key_pulse(2'd0);
    chk("hold_disarm", {1'b0, DEBUG_STATE}, 4'd0);
    for (int i = 0; i < 3; i++) key_pulse(2'd2);
    chk("err_state", {1'b0, DEBUG_STATE}, 4'd0);
    chk("err_locked", {3'b0, LOCKED}, {3'b0, LOCK_EXP});
    key_pulse(2'd0);
    chk("err_ok_state", {1'b0, DEBUG_STATE}, {1'b0, 2'b0, ~LOCK_EXP});
`ifdef ALARM_LOCKOUT_EN
    wait_for("lock_release", 2, 3'd0, 50);
    key_pulse(2'd0);
    chk("lock_ok_after", {1'b0, DEBUG_STATE}, 4'd1);
`endif
    key_pulse(2'd0);
    chk("err_disarm", {1'b0, DEBUG_STATE}, 4'd0);
    key_pulse(2'd0);
    wait_for("rst_path_armed", 0, 3'd2, 40);
    SENSOR = 4'b1000;
    wait_for("rst_path_alarm", 0, 3'd4, 30);
    SENSOR = 4'b0;
    chk("rst_path_siren", {3'b0, SIREN}, 4'd1);
    RST_N = 1'b0;
    #2;
    chk("async_siren", {3'b0, SIREN}, 4'd0);
    chk("async_state", {1'b0, DEBUG_STATE}, 4'd0);
    chk("async_led", {3'b0, ARMED_LED}, 4'd0);
    chk("async_beep", {3'b0, BEEP}, 4'd0);
    #2 RST_N = 1'b1;
    step(2);
    chk("post_rst_state", {1'b0, DEBUG_STATE}, 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
